// File: rtl/matrix_wr_if.sv
// Cell-write request channel for the board matrix.
// One requester drives req/row/col/data and holds req until it sees ack.
// The matrix owner returns ack as a one-cycle pulse on the cycle after
// the write has been committed.
//   req   requester -> owner  write request, level, held until ack
//   row   requester -> owner  target row
//   col   requester -> owner  target column
//   data  requester -> owner  value to store
//   ack   owner -> requester  one-cycle pulse: write committed
interface matrix_wr_if #(
    parameter int RW    = 3,
    parameter int CW    = 3,
    parameter int WIDTH = 9
);
    logic             req;
    logic [RW-1:0]    row;
    logic [CW-1:0]    col;
    logic [WIDTH-1:0] data;
    logic             ack;

    modport master (output req, output row, output col, output data, input ack);
    modport slave  (input req, input row, input col, input data, output ack);
endinterface

// File: rtl/matrix_access_ctrl.sv
// Board matrix owner: holds the ROWS x COLS matrix of WIDTH-bit cells and is
// its only writer.
//   clk, reset   single clock, synchronous active-high reset
//   clear_req    level request for a row-sequenced full-board clear
//   busy         high for exactly ROWS cycles while the clear runs
//   clear_done   one-cycle pulse after the last row has been cleared
//   a_if, b_if   write channels (A: game logic, B: tile generator),
//                round-robin arbitrated, at most one write per edge
//   rd_row/col   read address; rd_data returns the stored cell one cycle later
//   cells        flat combinational view, cell(r,c) at [(r*COLS+c)*WIDTH +: WIDTH]
//   occupied     number of nonzero cells
//   full         occupied == ROWS*COLS
module matrix_access_ctrl #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int WIDTH = 9,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int NW   = $clog2(ROWS*COLS+1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear_req,
    output logic                        busy,
    output logic                        clear_done,
    matrix_wr_if.slave                  a_if,
    matrix_wr_if.slave                  b_if,
    input  logic [RW-1:0]               rd_row,
    input  logic [CW-1:0]               rd_col,
    output logic [WIDTH-1:0]            rd_data,
    output logic [ROWS*COLS*WIDTH-1:0]  cells,
    output logic [NW-1:0]               occupied,
    output logic                        full
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t             state_q;
    logic [RW-1:0]      row_ptr_q;
    logic               busy_q;
    logic               clear_done_q;
    logic               a_ack_q;
    logic               b_ack_q;
    logic               rr_q;          // 0: A wins a tie, 1: B wins a tie
    logic [WIDTH-1:0]   rd_data_q;
    logic [NW-1:0]      occupied_q;
    logic [WIDTH-1:0]   mem_q [ROWS][COLS];

    logic [WIDTH-1:0]   mem_d [ROWS][COLS];
    logic [NW-1:0]      occupied_d;

    logic               elig_a;
    logic               elig_b;
    logic               grant_ok;
    logic               win_a;
    logic               win_b;
    logic               wr_en;
    logic [RW-1:0]      wr_row;
    logic [CW-1:0]      wr_col;
    logic [WIDTH-1:0]   wr_data;
    logic               wr_in_range;
    logic [WIDTH-1:0]   wr_old;
    logic               rd_in_range;
    logic [WIDTH-1:0]   rd_val;
    logic [COLS-1:0]    clr_row_nz;
    logic [NW-1:0]      clr_cnt;

    // Nonzero flags of the row currently being cleared, used to take the
    // whole row's contribution out of the occupied count in one edge.
    genvar gi, gj;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_clr_nz
            assign clr_row_nz[gi] = |mem_q[row_ptr_q][gi];
        end
    endgenerate

    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                assign cells[(gi*COLS+gj)*WIDTH +: WIDTH] = mem_q[gi][gj];
            end
        end
    endgenerate

    always_comb begin
        // A requester whose ack is high this cycle was just served; masking it
        // keeps a still-high req from producing a second write.
        elig_a   = a_if.req & ~a_ack_q;
        elig_b   = b_if.req & ~b_ack_q;
        grant_ok = (state_q == S_IDLE) & ~clear_req;
        win_a    = grant_ok & elig_a & (~elig_b | ~rr_q);
        win_b    = grant_ok & elig_b & (~elig_a |  rr_q);
        wr_en    = win_a | win_b;

        wr_row   = win_b ? b_if.row  : a_if.row;
        wr_col   = win_b ? b_if.col  : a_if.col;
        wr_data  = win_b ? b_if.data : a_if.data;

        wr_in_range = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
        wr_old      = wr_in_range ? mem_q[wr_row][wr_col] : '0;

        rd_in_range = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
        rd_val      = rd_in_range ? mem_q[rd_row][rd_col] : '0;

        clr_cnt  = NW'($countones(clr_row_nz));

        mem_d      = mem_q;
        occupied_d = occupied_q;
        if (state_q == S_CLEAR) begin
            for (int c = 0; c < COLS; c++) begin
                mem_d[row_ptr_q][c] = '0;
            end
            occupied_d = occupied_q - clr_cnt;
        end else if (wr_en && wr_in_range) begin
            mem_d[wr_row][wr_col] = wr_data;
            if ((wr_old == '0) && (wr_data != '0)) begin
                occupied_d = occupied_q + NW'(1);
            end else if ((wr_old != '0) && (wr_data == '0)) begin
                occupied_d = occupied_q - NW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            row_ptr_q    <= '0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            rr_q         <= 1'b0;
            rd_data_q    <= '0;
            occupied_q   <= '0;
            mem_q        <= '{default: '0};
        end else begin
            mem_q        <= mem_d;
            occupied_q   <= occupied_d;
            rd_data_q    <= rd_val;
            a_ack_q      <= win_a;
            b_ack_q      <= win_b;
            clear_done_q <= 1'b0;
            // Pointer only moves on contention, and always to the loser.
            if (grant_ok && elig_a && elig_b) begin
                rr_q <= win_a;
            end
            case (state_q)
                S_IDLE: begin
                    if (clear_req) begin
                        state_q   <= S_CLEAR;
                        row_ptr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    row_ptr_q <= row_ptr_q + RW'(1);
                    if (row_ptr_q == RW'(ROWS-1)) begin
                        state_q      <= S_IDLE;
                        busy_q       <= 1'b0;
                        clear_done_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign clear_done = clear_done_q;
    assign a_if.ack   = a_ack_q;
    assign b_if.ack   = b_ack_q;
    assign rd_data    = rd_data_q;
    assign occupied   = occupied_q;
    assign full       = (occupied_q == NW'(ROWS*COLS));

endmodule

// File: tb/tb_matrix_access_ctrl.sv
module tb_matrix_access_ctrl;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int WIDTH = 9;
    localparam int NCELL = ROWS*COLS;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       clear_req;
    logic                       busy;
    logic                       clear_done;
    logic [2:0]                 rd_row;
    logic [2:0]                 rd_col;
    logic [WIDTH-1:0]           rd_data;
    logic [NCELL*WIDTH-1:0]     cells;
    logic [6:0]                 occupied;
    logic                       full;

    matrix_wr_if #(.RW(3), .CW(3), .WIDTH(WIDTH)) a_if ();
    matrix_wr_if #(.RW(3), .CW(3), .WIDTH(WIDTH)) b_if ();

    matrix_access_ctrl #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done),
        .a_if       (a_if),
        .b_if       (b_if),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_data    (rd_data),
        .cells      (cells),
        .occupied   (occupied),
        .full       (full)
    );

    always #5 clk = ~clk;

    // Reference model: plain array of cell values; occupancy is recounted
    // from scratch each time it is needed.
    logic [WIDTH-1:0] mdl [NCELL];
    int vectors     = 0;
    int miscompares = 0;

    function automatic int mdl_occ();
        int n = 0;
        for (int i = 0; i < NCELL; i++) if (mdl[i] != 0) n++;
        return n;
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < NCELL; i++) mdl[i] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_board(input string tag);
        int occ;
        for (int i = 0; i < NCELL; i++)
            chk($sformatf("%s_cell%0d", tag, i), 64'(cells[i*WIDTH +: WIDTH]), 64'(mdl[i]));
        occ = mdl_occ();
        chk({tag, "_occupied"}, 64'(occupied), 64'(occ));
        chk({tag, "_full"}, 64'(full), 64'(occ == NCELL));
        $display("board %s: occupied=%0d full=%0b", tag, occupied, full);
    endtask

    // Single-requester write; the request is dropped as soon as ack is seen.
    task automatic do_write(input bit sel, input int r, input int c, input logic [WIDTH-1:0] d);
        bit got = 0;
        if (!sel) begin
            a_if.req = 1'b1; a_if.row = 3'(r); a_if.col = 3'(c); a_if.data = d;
        end else begin
            b_if.req = 1'b1; b_if.row = 3'(r); b_if.col = 3'(c); b_if.data = d;
        end
        for (int n = 0; n < 4 && !got; n++) begin
            tick();
            if (sel ? b_if.ack : a_if.ack) got = 1;
        end
        a_if.req = 1'b0;
        b_if.req = 1'b0;
        chk($sformatf("wr_ack_%s", sel ? "B" : "A"), 64'(got), 64'd1);
        if (got) mdl[r*COLS+c] = d;
        chk("wr_occupied", 64'(occupied), 64'(mdl_occ()));
        chk("wr_cell", 64'(cells[(r*COLS+c)*WIDTH +: WIDTH]), 64'(mdl[r*COLS+c]));
        tick();
        chk("wr_ack_pulse", 64'(sel ? b_if.ack : a_if.ack), 64'd0);
        $display("write %s (%0d,%0d)=%03h ack=%0b occupied=%0d", sel ? "B" : "A", r, c, d, got, occupied);
    endtask

    task automatic do_read(input int r, input int c);
        rd_row = 3'(r);
        rd_col = 3'(c);
        tick();
        chk("rd_data", 64'(rd_data), 64'(mdl[r*COLS+c]));
        $display("read (%0d,%0d) -> %03h", r, c, rd_data);
    endtask

    // Full clear, optionally with a concurrent A request and/or a re-pulse
    // of clear_req while the clear is running.
    task automatic run_clear(input bit with_a, input bit repulse, input string tag);
        int busy_cnt = 0, done_cnt = 0, ack_cnt = 0, done_at = -1, ack_at = -1;
        bit ack_busy = 0;
        clear_req = 1'b1;
        if (with_a) begin
            a_if.req = 1'b1; a_if.row = 3'd3; a_if.col = 3'd3; a_if.data = 9'h0AB;
        end
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (busy) busy_cnt++;
            if (clear_done) begin done_cnt++; done_at = i; end
            if (a_if.ack) begin
                ack_cnt++; ack_at = i;
                if (busy) ack_busy = 1;
                a_if.req = 1'b0;
            end
            clear_req = (repulse && i == 2);
            tick();
        end
        clear_req = 1'b0;
        a_if.req  = 1'b0;
        mdl_clear();
        if (with_a) mdl[3*COLS+3] = 9'h0AB;
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(ROWS));
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_done_at"}, 64'(done_at), 64'(ROWS));
        chk({tag, "_ack_count"}, 64'(ack_cnt), 64'(with_a ? 1 : 0));
        chk({tag, "_ack_during_busy"}, 64'(ack_busy), 64'd0);
        if (with_a) chk({tag, "_ack_at"}, 64'(ack_at), 64'(ROWS + 1));
        $display("clear %s: busy=%0d done=%0d@%0d ack=%0d@%0d", tag, busy_cnt, done_cnt, done_at, ack_cnt, ack_at);
        check_board(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear_req = 1'b0; rd_row = '0; rd_col = '0;
        a_if.req = 1'b0; a_if.row = '0; a_if.col = '0; a_if.data = '0;
        b_if.req = 1'b0; b_if.row = '0; b_if.col = '0; b_if.data = '0;
        mdl_clear();
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_clear_done", 64'(clear_done), 64'd0);
        chk("rst_a_ack", 64'(a_if.ack), 64'd0);
        chk("rst_b_ack", 64'(b_if.ack), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        check_board("reset");

        // Reset while the clear is at row_ptr=3
        do_write(0, 6, 1, 9'h055);
        do_write(1, 7, 0, 9'h100);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mdl_clear();
        chk("midclr_busy", 64'(busy), 64'd0);
        chk("midclr_done", 64'(clear_done), 64'd0);
        check_board("midclr");
        tick();
        chk("midclr_done_later", 64'(clear_done), 64'd0);
        chk("midclr_busy_later", 64'(busy), 64'd0);

        // Single write and read-back
        do_write(0, 2, 5, 9'h1FF);
        chk("t2_occupied", 64'(occupied), 64'd1);
        do_read(2, 5);

        // Both requesters together: A wins first after reset, then B; the
        // next tie goes to B.
        a_if.req = 1'b1; a_if.row = 3'd0; a_if.col = 3'd1; a_if.data = 9'h011;
        b_if.req = 1'b1; b_if.row = 3'd0; b_if.col = 3'd2; b_if.data = 9'h022;
        tick();
        chk("rr1_a_ack", 64'(a_if.ack), 64'd1);
        chk("rr1_b_ack", 64'(b_if.ack), 64'd0);
        a_if.req = 1'b0; mdl[1] = 9'h011;
        tick();
        chk("rr2_b_ack", 64'(b_if.ack), 64'd1);
        chk("rr2_a_ack", 64'(a_if.ack), 64'd0);
        b_if.req = 1'b0; mdl[2] = 9'h022;
        tick();
        a_if.req = 1'b1; a_if.row = 3'd0; a_if.col = 3'd3; a_if.data = 9'h033;
        b_if.req = 1'b1; b_if.row = 3'd0; b_if.col = 3'd4; b_if.data = 9'h044;
        tick();
        chk("rr3_b_ack", 64'(b_if.ack), 64'd1);
        chk("rr3_a_ack", 64'(a_if.ack), 64'd0);
        b_if.req = 1'b0; mdl[4] = 9'h044;
        tick();
        chk("rr4_a_ack", 64'(a_if.ack), 64'd1);
        chk("rr4_b_ack", 64'(b_if.ack), 64'd0);
        a_if.req = 1'b0; mdl[3] = 9'h033;
        tick();
        chk("rr5_a_ack", 64'(a_if.ack), 64'd0);
        $display("arbitration sequence done");
        check_board("rr");

        // Random writes (zero data included) and reads
        for (int k = 0; k < 40; k++) begin
            logic [WIDTH-1:0] d;
            d = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
            do_write(1'($urandom_range(0, 1)), $urandom_range(0, ROWS-1), $urandom_range(0, COLS-1), d);
        end
        for (int k = 0; k < 12; k++) do_read($urandom_range(0, ROWS-1), $urandom_range(0, COLS-1));
        check_board("random");

        // Fill every cell nonzero, then zero the last one
        for (int i = 0; i < NCELL; i++)
            do_write(1'(i % 2), i / COLS, i % COLS, WIDTH'($urandom_range(1, (1 << WIDTH) - 1)));
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_occupied", 64'(occupied), 64'(NCELL));
        do_write(0, 7, 7, 9'h000);
        chk("unfill_full", 64'(full), 64'd0);
        chk("unfill_occupied", 64'(occupied), 64'(NCELL - 1));
        do_read(7, 6);

        // Clear with a simultaneous A request, then a clear re-pulsed mid-way
        run_clear(1'b1, 1'b0, "clr_a");
        do_read(3, 3);
        for (int i = 0; i < 10; i++)
            do_write(1'(i % 2), $urandom_range(0, ROWS-1), $urandom_range(0, COLS-1), WIDTH'($urandom_range(1, 511)));
        run_clear(1'b0, 1'b1, "clr_repulse");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
